// File: rtl/regbank_trace_unit.sv
// Per-instruction register trace: snapshots r0..rN-1, PC and IR on each re-entry to FETCH
// and streams the words out one per accepted beat on a valid/ready port.
module regbank_trace_unit #(
    parameter int              DW          = 16,
    parameter int              NREG        = 8,
    parameter int              SW          = 5,
    parameter logic [SW-1:0]   FETCH_STATE = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREG*DW-1:0] regbankmatrix,
    input  logic [DW-1:0]      pc_in,
    input  logic [DW-1:0]      ir_in,
    input  logic [SW-1:0]      cpu_state,
    input  logic               trace_en,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [3:0]         out_idx,
    output logic               busy,
    output logic [15:0]        snap_count,
    output logic [7:0]         drop_count,
    output logic               overflow
);

    localparam int         NWORD    = NREG + 2;
    localparam logic [3:0] LAST_IDX = 4'(NREG + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                     state;
    logic                       prev_fetch;
    logic [NWORD-1:0][DW-1:0]   shadow;
    logic                       is_fetch;
    logic                       bnd;
    logic                       accept;
    logic [3:0]                 nxt_idx;

    assign is_fetch = (cpu_state == FETCH_STATE);
    assign bnd      = is_fetch && !prev_fetch;
    assign accept   = out_valid && out_ready;
    assign nxt_idx  = out_idx + 4'd1;
    assign busy     = (state == SEND);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            prev_fetch <= 1'b1;
            shadow     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            snap_count <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            prev_fetch <= is_fetch;
            // Any boundary seen while streaming is lost, including one coinciding with the last accept.
            if (bnd && trace_en && state == SEND) begin
                if (drop_count != 8'hFF)
                    drop_count <= drop_count + 8'd1;
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bnd && trace_en) begin
                        for (int k = 0; k < NREG; k++)
                            shadow[k] <= regbankmatrix[k*DW +: DW];
                        shadow[NREG]   <= pc_in;
                        shadow[NREG+1] <= ir_in;
                        snap_count     <= snap_count + 16'd1;
                        out_valid      <= 1'b1;
                        out_idx        <= '0;
                        out_data       <= regbankmatrix[DW-1:0];
                        state          <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (out_idx == LAST_IDX) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            out_idx  <= nxt_idx;
                            out_data <= shadow[nxt_idx];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_trace_unit.sv
// Directed bench for regbank_trace_unit: scoreboard of expected beats checked at accept time,
// plus stall-hold, drop-counter, reset-abort and trace_en checks.
module tb_regbank_trace_unit;

    localparam int DW = 16;
    localparam int NREG = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREG*DW-1:0] regbankmatrix;
    logic [DW-1:0]      pc_in, ir_in;
    logic [4:0]         cpu_state;
    logic               trace_en, out_ready;
    logic               out_valid, busy, overflow;
    logic [DW-1:0]      out_data;
    logic [3:0]         out_idx;
    logic [15:0]        snap_count;
    logic [7:0]         drop_count;

    typedef struct {
        logic [3:0]    idx;
        logic [DW-1:0] data;
    } beat_t;

    beat_t q[$];
    int tests = 0;
    int fails = 0;

    regbank_trace_unit #(.DW(DW), .NREG(NREG), .SW(5), .FETCH_STATE(5'd0)) dut (
        .clk(clk), .rst(rst), .regbankmatrix(regbankmatrix), .pc_in(pc_in), .ir_in(ir_in),
        .cpu_state(cpu_state), .trace_en(trace_en), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx), .busy(busy),
        .snap_count(snap_count), .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accepted beats are popped from the scoreboard; stalled beats must not move.
    logic          hold_pend = 1'b0;
    logic [DW-1:0] held_data;
    logic [3:0]    held_idx;
    always @(negedge clk) begin
        if (!rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && out_valid) begin
                chk("hold_data", 32'(out_data), 32'(held_data));
                chk("hold_idx", 32'(out_idx), 32'(held_idx));
            end
            hold_pend = 1'b0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 32'(out_idx), 32'hFFFF_FFFF);
                end else begin
                    beat_t b;
                    b = q.pop_front();
                    chk("beat_idx", 32'(out_idx), 32'(b.idx));
                    chk("beat_data", 32'(out_data), 32'(b.data));
                end
            end else if (out_valid) begin
                hold_pend = 1'b1;
                held_data = out_data;
                held_idx  = out_idx;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_regs(input logic [DW-1:0] base, input logic [DW-1:0] pc, input logic [DW-1:0] ir);
        for (int k = 0; k < NREG; k++)
            regbankmatrix[k*DW +: DW] = base + DW'(k);
        pc_in = pc;
        ir_in = ir;
    endtask

    task automatic push_snap();
        beat_t b;
        for (int k = 0; k < NREG + 2; k++) begin
            b.idx  = 4'(k);
            b.data = (k < NREG) ? regbankmatrix[k*DW +: DW] : (k == NREG ? pc_in : ir_in);
            q.push_back(b);
        end
    endtask

    // Leave FETCH for one cycle then return; the return cycle is the boundary.
    task automatic boundary(input bit expect_capture);
        cpu_state = 5'd3;
        step();
        cpu_state = 5'd0;
        if (expect_capture) push_snap();
        step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        q.delete();
        cpu_state = 5'd0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && (q.size() != 0 || out_valid); i++) step();
        chk(tag, 32'(q.size() == 0 && !out_valid), 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        trace_en = 1'b1;
        out_ready = 1'b1;
        cpu_state = 5'd0;
        set_regs(16'd1, 16'h0010, 16'hABCD);

        // 1) reset values then one full back-to-back stream
        do_reset();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_idx", 32'(out_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_snap", 32'(snap_count), 0);
        chk("rst_drop", 32'(drop_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        boundary(1);
        for (int k = 0; k < NREG + 2; k++) begin
            chk("t1_valid", 32'(out_valid), 1);
            chk("t1_idx", 32'(out_idx), 32'(k));
            step();
        end
        chk("t1_done_valid", 32'(out_valid), 0);
        chk("t1_done_busy", 32'(busy), 0);
        chk("t1_snap", 32'(snap_count), 1);
        drain("t1_drain");

        // 2) FETCH held from reset: no spurious boundary
        do_reset();
        begin
            int seen = 0;
            for (int i = 0; i < 50; i++) begin
                step();
                if (out_valid) seen++;
            end
            chk("t2_no_valid", 32'(seen), 0);
        end
        chk("t2_snap", 32'(snap_count), 0);

        // 3) stalled consumer: 1,0,0,1 ready pattern
        boundary(1);
        for (int i = 0; i < 200 && (q.size() != 0 || out_valid); i++) begin
            out_ready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        out_ready = 1'b1;
        drain("t3_drain");
        chk("t3_snap", 32'(snap_count), 1);

        // 4) drops while stalled, then saturation
        do_reset();
        out_ready = 1'b0;
        set_regs(16'h0040, 16'h0123, 16'h4567);
        boundary(1);
        set_regs(16'h0900, 16'h0999, 16'h0888);
        for (int i = 0; i < 3; i++) boundary(0);
        chk("t4_drop3", 32'(drop_count), 3);
        chk("t4_ovf", 32'(overflow), 1);
        chk("t4_busy", 32'(busy), 1);
        for (int i = 0; i < 300; i++) boundary(0);
        chk("t4_drop_sat", 32'(drop_count), 32'hFF);
        out_ready = 1'b1;
        drain("t4_drain");
        chk("t4_snap", 32'(snap_count), 1);

        // 5) reset mid-stream aborts immediately
        do_reset();
        set_regs(16'h0020, 16'h0030, 16'h0031);
        boundary(1);
        for (int i = 0; i < 10 && out_idx != 4'd4; i++) step();
        chk("t5_at_idx4", 32'(out_idx), 4);
        rst = 1'b0;
        q.delete();
        #1;
        chk("t5_valid", 32'(out_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_snap", 32'(snap_count), 0);
        chk("t5_drop", 32'(drop_count), 0);
        step();
        rst = 1'b1;
        step();
        chk("t5_quiet", 32'(out_valid), 0);
        boundary(1);
        chk("t5_restart_idx", 32'(out_idx), 0);
        drain("t5_drain");

        // 6) trace_en=0 ignores boundaries; captured words survive register changes
        trace_en = 1'b0;
        boundary(0);
        boundary(0);
        chk("t6_no_capture", 32'(out_valid), 0);
        chk("t6_snap", 32'(snap_count), 1);
        chk("t6_drop", 32'(drop_count), 0);
        trace_en = 1'b1;
        out_ready = 1'b0;
        set_regs(16'h0100, 16'h1111, 16'h2222);
        boundary(1);
        set_regs(16'h0200, 16'h3333, 16'h4444);
        trace_en = 1'b0;
        boundary(0);
        chk("t6_drop_en0", 32'(drop_count), 0);
        trace_en = 1'b1;
        out_ready = 1'b1;
        drain("t6_drain");
        chk("t6_snap2", 32'(snap_count), 2);

        // 7) boundary coinciding with the final accept is dropped, not captured
        do_reset();
        boundary(1);
        for (int i = 0; i < 8; i++) step();
        cpu_state = 5'd3;
        step();
        chk("t7_idx9", 32'(out_idx), 9);
        cpu_state = 5'd0;
        step();
        chk("t7_valid", 32'(out_valid), 0);
        chk("t7_drop", 32'(drop_count), 1);
        chk("t7_ovf", 32'(overflow), 1);
        chk("t7_snap", 32'(snap_count), 1);
        step();
        step();
        chk("t7_no_recapture", 32'(busy), 0);
        chk("t7_queue", 32'(q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
